tl_phase_scheduler: RTL
=======================

Name: tl_phase_scheduler

Overview:
Sequences the phases of a two-road intersection: green, yellow and all-red for road A and road B, plus an optional pedestrian walk phase. Generates the "logic second" tick from the system clock. Drives per-road light codes and a remaining-seconds count consumed by the existing 7-segment display path. Sits between the top level (en, clk, rst_n) and the light/segment output logic.

Parameters:
CLK_DIV, 1, clk cycles per logic second (≥1); 1 = one tick per cycle for fast simulation
GREEN_T, 9, green duration in seconds (1..99)
YELLOW_T, 3, yellow duration in seconds (1..99)
ALLRED_T, 1, all-red clearance duration in seconds (1..99)
WALK_T, 5, pedestrian walk duration in seconds (1..99)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 = suspend
ped_req  in  1  pedestrian request; level or pulse, sampled every clk
light_a  out  2  road A light: 00 red, 01 yellow, 10 green, 11 off
light_b  out  2  road B light, same encoding
count  out  7  remaining seconds in current phase, binary, range DUR..1
phase  out  3  current state encoding
ped_walk  out  1  1 while in WALK

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state AR_A, count=ALLRED_T, prescaler=0, ped_pending=0, light_a=light_b=00, ped_walk=0.
- Prescaler: counts 0..CLK_DIV-1 while en=1. tick=1 on the cycle it equals CLK_DIV-1, then it wraps to 0. Prescaler is held while en=0.
- States and light codes:
  - AR_A (A red, B red) → GA (A 10, B 00) → YA (A 01, B 00) → AR_B (red/red) → GB (A 00, B 10) → YB (A 00, B 01) → AR_A.
  - WALK: both 00, ped_walk=1.
- Phase entry loads count with that phase's duration.
- On tick:
  - count>1: count decrements.
  - count==1: advance to the next state. Transition is registered, so the new phase is visible the cycle after the tick.
- Pedestrian handling:
  - ped_req=1 in any state except WALK sets ped_pending.
  - On the tick that ends AR_A or AR_B with ped_pending=1: enter WALK, load WALK_T, clear ped_pending.
  - WALK exits to the green that the all-red led to (GA after AR_A, GB after AR_B). A 1-bit return flag records which.
  - ped_req during WALK is ignored. ped_req on the same cycle pending is cleared is absorbed, not re-latched.
- Nominal cycle without requests: 1+9+3+1+9+3 = 26 ticks.
- en=0:
  - state, count and ped_pending freeze; ped_req is still latched.
  - light_a/light_b = 11, ped_walk=0.
  - On en rising, outputs resume from the frozen state and count; prescaler continues from its held value.
- Reset mid-phase returns to reset values immediately (asynchronous), independent of en.
- Outputs light_a, light_b, phase and ped_walk decode combinationally from registered state. count is a register.

Optional Feature:
TL_FLASH_YELLOW_EN:
- Defined: while en=0 the prescaler keeps running. A blink flop toggles each tick. light_a=light_b=01 when blink=1, else 11. Blink resets to 0 and clears when en=1. State and count still freeze.
- Undefined: en=0 behaviour as above (lights 11, prescaler held). No blink flop exists.

Decomposition:
- Package tl_pkg:
  - state enum localparams (AR_A=0, GA=1, YA=2, AR_B=3, GB=4, YB=5, WALK=6)
  - light codes (L_RED=2'b00, L_YEL=2'b01, L_GRN=2'b10, L_OFF=2'b11)
  - COUNT_W=7
- Sub-module tl_tick_gen: the CLK_DIV prescaler. Inputs clk, rst_n, run; output tick.

Test Plan:
- Reset, en=1, CLK_DIV=1, defaults → phase sequence AR_A(1), GA(9), YA(3), AR_B(1), GB(9), YB(3); period exactly 26 cycles; count during GA reads 9,8,…,1.
- Pulse ped_req 1 cycle during GA → after AR_B ends, WALK with count 5 and ped_walk=1 for 5 ticks, then GB with count 9; lights 00/00 throughout WALK.
- Hold ped_req high through WALK → exactly one WALK inserted per all-red boundary; second WALK follows the next AR_A only because the request was re-latched after WALK ended.
- Drop en mid-GB at count=4 for 10 cycles → lights 11/11, count holds 4; after re-enable count continues 3,2,1 then YB.
- Assert rst_n=0 mid-YA asynchronously (between clock edges) → outputs immediately 00/00, phase AR_A, count=1, ped_walk=0.
- CLK_DIV=4, TL_FLASH_YELLOW_EN defined, en=0 → light_a/light_b alternate 01/11 every 4 cycles; count and phase unchanged.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase scheduler.
package tl_pkg;

  localparam int COUNT_W = 7;

  typedef enum logic [2:0] {
    AR_A = 3'd0,
    GA   = 3'd1,
    YA   = 3'd2,
    AR_B = 3'd3,
    GB   = 3'd4,
    YB   = 3'd5,
    WALK = 3'd6
  } tl_state_e;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

endpackage

// File: rtl/tl_tick_gen.sv
// Logic-second prescaler: one tick every CLK_DIV clocks while run is high,
// count held while run is low.
module tl_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at CLK_DIV-1 and flag that cycle as the tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Two-road intersection phase sequencer with pedestrian walk insertion.
// Optional build macro TL_FLASH_YELLOW_EN: flash yellow while suspended (en=0).
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int GREEN_T  = 9,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ped_req,
  output logic [1:0]         light_a,
  output logic [1:0]         light_b,
  output logic [COUNT_W-1:0] count,
  output logic [2:0]         phase,
  output logic               ped_walk
);

  function automatic logic [COUNT_W-1:0] dur_of(input tl_state_e s);
    case (s)
      GA, GB:  dur_of = COUNT_W'(GREEN_T);
      YA, YB:  dur_of = COUNT_W'(YELLOW_T);
      WALK:    dur_of = COUNT_W'(WALK_T);
      default: dur_of = COUNT_W'(ALLRED_T);
    endcase
  endfunction

  tl_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ped_pending_q, ped_pending_d;
  logic               ret_b_q, ret_b_d;
  logic               run;
  logic               tick;
  logic               step;
  logic [1:0]         susp_light;

`ifdef TL_FLASH_YELLOW_EN
  logic blink_q, blink_d;
  assign run = 1'b1;

  // Blink toggles per tick while suspended and is parked at 0 while running.
  always_comb begin
    if (en) begin
      blink_d = 1'b0;
    end else if (tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign susp_light = blink_q ? L_YEL : L_OFF;
`else
  assign run        = en;
  assign susp_light = L_OFF;
`endif

  tl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  assign step = en & tick;

  // Next phase/count; a clear on walk entry overrides a same-cycle request.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    ret_b_d       = ret_b_q;
    if (ped_req && (state_q != WALK)) begin
      ped_pending_d = 1'b1;
    end else begin
      ped_pending_d = ped_pending_q;
    end
    if (step) begin
      if (count_q > COUNT_W'(1'b1)) begin
        count_d = count_q - COUNT_W'(1'b1);
      end else begin
        case (state_q)
          AR_A: begin
            if (ped_pending_q) begin
              state_d       = WALK;
              ret_b_d       = 1'b0;
              ped_pending_d = 1'b0;
            end else begin
              state_d = GA;
            end
          end
          GA:   state_d = YA;
          YA:   state_d = AR_B;
          AR_B: begin
            if (ped_pending_q) begin
              state_d       = WALK;
              ret_b_d       = 1'b1;
              ped_pending_d = 1'b0;
            end else begin
              state_d = GB;
            end
          end
          GB:      state_d = YB;
          YB:      state_d = AR_A;
          WALK:    state_d = ret_b_q ? GB : GA;
          default: state_d = AR_A;
        endcase
        count_d = dur_of(state_d);
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= AR_A;
      count_q       <= COUNT_W'(ALLRED_T);
      ped_pending_q <= 1'b0;
      ret_b_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      ret_b_q       <= ret_b_d;
    end
  end

  // Light decode from the registered phase; suspension overrides.
  always_comb begin
    light_a  = L_RED;
    light_b  = L_RED;
    ped_walk = 1'b0;
    case (state_q)
      GA:      light_a  = L_GRN;
      YA:      light_a  = L_YEL;
      GB:      light_b  = L_GRN;
      YB:      light_b  = L_YEL;
      WALK:    ped_walk = 1'b1;
      default: ped_walk = 1'b0;
    endcase
    if (!en) begin
      light_a  = susp_light;
      light_b  = susp_light;
      ped_walk = 1'b0;
    end else begin
      ped_walk = ped_walk & en;
    end
  end

  assign count = count_q;
  assign phase = state_q;

endmodule
